// File: rtl/cdma_pkg.sv
// Shared types and constants for the CDMA command splitter.
// States, datamover limits and the default address width.
package cdma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    CPL   = 2'd3
  } cdma_split_state_t;

  localparam int CDMA_BTT_MAX  = 2**23 - 1;
  localparam int CDMA_4K       = 4096;
  localparam int AXI_ADDR_BITS = 32;

endpackage

// File: rtl/cdma_split_chunk_calc.sv
// Next chunk length from current address and remaining bytes.
// CDMA_SPLIT_4K_EN adds the 4 KiB boundary limit.
module cdma_split_chunk_calc
  import cdma_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 32,
  parameter int MAX_CHUNK = 2**22
) (
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [LEN_BITS-1:0]  rem,
  output logic [LEN_BITS-1:0]  len
);

  localparam logic [LEN_BITS-1:0] MAXC = LEN_BITS'(MAX_CHUNK);

  logic [LEN_BITS-1:0] cap;

  assign cap = (rem < MAXC) ? rem : MAXC;

`ifdef CDMA_SPLIT_4K_EN
  // Bytes left before the next 4 KiB boundary: 1..4096
  logic [12:0]         room;
  logic [LEN_BITS-1:0] room_w;

  assign room   = 13'(CDMA_4K) - {1'b0, addr[11:0]};
  assign room_w = LEN_BITS'(room);
  assign len    = (cap < room_w) ? cap : room_w;
`else
  logic unused_addr;

  assign unused_addr = ^addr;
  assign len         = cap;
`endif

endmodule

// File: rtl/cdma_cmd_splitter.sv
// Splits one long transfer into datamover commands, limits outstanding.
// Optional CDMA_SPLIT_4K_EN keeps every chunk inside a 4 KiB page.
module cdma_cmd_splitter
  import cdma_pkg::*;
#(
  parameter int ADDR_BITS       = AXI_ADDR_BITS,
  parameter int LEN_BITS        = 32,
  parameter int MAX_CHUNK       = 2**22,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_req_valid,
  output logic                 s_req_ready,
  input  logic [ADDR_BITS-1:0] s_req_paddr,
  input  logic [LEN_BITS-1:0]  s_req_len,
  output logic                 s_cpl,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [ADDR_BITS-1:0] cmd_paddr,
  output logic [LEN_BITS-1:0]  cmd_len,
  input  logic                 cmd_done,
  output logic                 busy,
  output logic                 err
);

  localparam int            OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);

  cdma_split_state_t state;

  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  rem_q;
  logic [LEN_BITS-1:0]  chunk;
  logic [LEN_BITS-1:0]  rem_nx;
  logic [OW-1:0]        outs;
  logic [OW-1:0]        outs_nx;
  logic                 ready_q;
  logic                 valid_q;
  logic                 cpl_q;
  logic                 busy_q;
  logic                 err_q;
  logic                 acc;
  logic                 hs;
  logic                 dec;

  cdma_split_chunk_calc #(
    .ADDR_BITS (ADDR_BITS),
    .LEN_BITS  (LEN_BITS),
    .MAX_CHUNK (MAX_CHUNK)
  ) u_calc (
    .addr (addr_q),
    .rem  (rem_q),
    .len  (chunk)
  );

  assign acc    = s_req_valid & ready_q;
  assign hs     = valid_q & cmd_ready;
  assign dec    = cmd_done & (outs != '0);
  assign rem_nx = rem_q - chunk;

  always_comb begin
    outs_nx = outs;
    unique case ({hs, dec})
      2'b10:   outs_nx = outs + OW'(1);
      2'b01:   outs_nx = outs - OW'(1);
      default: outs_nx = outs;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      outs    <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      cpl_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      outs  <= outs_nx;
      cpl_q <= 1'b0;
      if (cmd_done && outs == '0) err_q <= 1'b1;
      if (cpl_q) busy_q <= 1'b0;
      unique case (state)
        IDLE: begin
          ready_q <= !acc;
          if (acc) begin
            addr_q <= s_req_paddr;
            rem_q  <= s_req_len;
            busy_q <= 1'b1;
            if (s_req_len == '0) begin
              state <= CPL;
            end else begin
              state   <= ISSUE;
              valid_q <= outs_nx < OMAX;
            end
          end
        end
        ISSUE: begin
          // Valid only drops on the final handshake or at the limit
          valid_q <= !(hs && rem_nx == '0) && (outs_nx < OMAX);
          if (hs) begin
            addr_q <= addr_q + ADDR_BITS'(chunk);
            rem_q  <= rem_nx;
            if (rem_nx == '0) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (outs == '0) state <= CPL;
        end
        CPL: begin
          cpl_q   <= 1'b1;
          ready_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign s_req_ready = ready_q;
  assign s_cpl       = cpl_q;
  assign cmd_valid   = valid_q;
  assign cmd_paddr   = addr_q;
  assign cmd_len     = chunk;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cdma_cmd_splitter.sv
// Randomized bench for cdma_cmd_splitter with a queue-based reference.
// Honours CDMA_SPLIT_4K_EN in the reference and the 4 KiB directed case.
module tb_cdma_cmd_splitter;

  localparam int AB = 32;
  localparam int LB = 32;
  localparam int MC = 4096;
  localparam int MO = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_req_valid = 1'b0;
  logic          s_req_ready;
  logic [AB-1:0] s_req_paddr = '0;
  logic [LB-1:0] s_req_len = '0;
  logic          s_cpl;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [AB-1:0] cmd_paddr;
  logic [LB-1:0] cmd_len;
  logic          cmd_done = 1'b0;
  logic          busy;
  logic          err;

  cdma_cmd_splitter #(
    .ADDR_BITS       (AB),
    .LEN_BITS        (LB),
    .MAX_CHUNK       (MC),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_req_valid (s_req_valid),
    .s_req_ready (s_req_ready),
    .s_req_paddr (s_req_paddr),
    .s_req_len   (s_req_len),
    .s_cpl       (s_cpl),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_paddr   (cmd_paddr),
    .cmd_len     (cmd_len),
    .cmd_done    (cmd_done),
    .busy        (busy),
    .err         (err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [AB-1:0] a;
    logic [LB-1:0] n;
  } cmd_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
                  nm, act, exp, $time);
  endtask

  // reference state
  cmd_t exp_q[$];
  cmd_t log_q[$];
  int   done_due[$];
  int   cyc = 0;
  int   since_rst = 0;
  int   out_m = 0;
  bit   act_m = 1'b0;
  bit   busy_m = 1'b0;
  bit   err_m = 1'b0;
  int   cpl_at = -1;
  int   cpl_cnt = 0;
  int   acc_c = -1;
  int   first_v = -1;
  int   cpl_c = -1;

  // stimulus knobs
  int rdy_pct = 100;
  int dly_min = 3;
  int dly_max = 3;
  bit hold_done = 1'b0;
  bit give_one = 1'b0;
  bit give_spur = 1'b0;
  bit rdy_low = 1'b0;

  function automatic void split(input logic [AB-1:0] a0,
                                input logic [LB-1:0] len);
    logic [AB-1:0] a;
    logic [LB-1:0] r;
    logic [LB-1:0] c;
    logic [LB-1:0] room;
    a = a0;
    r = len;
    while (r != 0) begin
      c = (r < LB'(MC)) ? r : LB'(MC);
`ifdef CDMA_SPLIT_4K_EN
      room = LB'(4096) - LB'(a[11:0]);
      if (c > room) c = room;
`else
      room = '0;
`endif
      exp_q.push_back('{a: a, n: c});
      a = a + AB'(c);
      r = r - c;
    end
  endfunction

  // driver for cmd_ready / cmd_done
  initial forever begin
    @(posedge aclk);
    cyc++;
    if (aresetn) since_rst++;
    else since_rst = 0;
    #1;
    cmd_ready = rdy_low ? 1'b0 : ($urandom_range(99) < rdy_pct);
    cmd_done = 1'b0;
    if (!hold_done || give_one) begin
      for (int i = 0; i < done_due.size(); i++) begin
        if (done_due[i] <= cyc) begin
          done_due.delete(i);
          cmd_done = 1'b1;
          give_one = 1'b0;
          break;
        end
      end
    end
    if (give_spur) begin
      cmd_done = 1'b1;
      give_spur = 1'b0;
    end
  end

  // compare process plus reference update
  initial forever begin
    bit exp_v;
    int ob;
    int c;
    @(negedge aclk);
    c = cyc;
    if (!aresetn) begin
      exp_q.delete();
      done_due.delete();
      out_m = 0;
      act_m = 0;
      busy_m = 0;
      err_m = 0;
      cpl_at = -1;
      continue;
    end
    exp_v = act_m && exp_q.size() > 0 && out_m < MO;
    chk("s_cpl", s_cpl, c == cpl_at);
    chk("busy", busy, busy_m);
    chk("s_req_ready", s_req_ready, !busy_m && since_rst >= 1);
    chk("cmd_valid", cmd_valid, exp_v);
    chk("err", err, err_m);
    if (cmd_valid && exp_q.size() > 0) begin
      chk("cmd_paddr", cmd_paddr, exp_q[0].a);
      chk("cmd_len", cmd_len, exp_q[0].n);
    end
    if (s_cpl) begin
      cpl_cnt++;
      cpl_c = c;
    end
    if (cmd_valid && first_v < 0) first_v = c;
    if (s_req_valid && s_req_ready) begin
      split(s_req_paddr, s_req_len);
      act_m = 1;
      busy_m = 1;
      acc_c = c;
      first_v = -1;
      if (s_req_len == 0) cpl_at = c + 2;
    end
    ob = out_m;
    if (cmd_valid && cmd_ready) begin
      log_q.push_back('{a: cmd_paddr, n: cmd_len});
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      out_m++;
      done_due.push_back(c + int'($urandom_range(dly_max, dly_min)));
    end
    if (cmd_done) begin
      if (ob == 0) err_m = 1;
      else out_m--;
    end
    if (c == cpl_at) begin
      act_m = 0;
      busy_m = 0;
      cpl_at = -1;
    end else if (act_m && exp_q.size() == 0 && out_m == 0 && cpl_at < 0) begin
      cpl_at = c + 3;
    end
  end

  task automatic do_req(input logic [AB-1:0] a, input logic [LB-1:0] n);
    int k;
    k = 0;
    @(posedge aclk);
    #1;
    s_req_valid = 1'b1;
    s_req_paddr = a;
    s_req_len = n;
    @(negedge aclk);
    while (!s_req_ready && k < 200) begin
      @(negedge aclk);
      k++;
    end
    chk("req_accept_wait", k < 200, 1);
    @(posedge aclk);
    #1;
    s_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    @(negedge aclk);
    while ((act_m || busy_m) && k < lim) begin
      @(negedge aclk);
      k++;
    end
    chk("idle_wait", k < lim, 1);
    repeat (2) @(negedge aclk);
  endtask

  task automatic clr_log();
    log_q.delete();
    cpl_cnt = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (2) @(posedge aclk);
    #3;
    chk("rst_ready", s_req_ready, 0);
    chk("rst_cpl", s_cpl, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_paddr", cmd_paddr, 0);
    chk("rst_len", cmd_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);

    // three chunks, dones three cycles after each issue
    clr_log();
    do_req(32'h1000, 10000);
    wait_idle(200);
    chk("t1_ncmd", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t1_a0", log_q[0].a, 32'h1000);
      chk("t1_n0", log_q[0].n, 4096);
      chk("t1_a1", log_q[1].a, 32'h2000);
      chk("t1_n1", log_q[1].n, 4096);
      chk("t1_a2", log_q[2].a, 32'h3000);
      chk("t1_n2", log_q[2].n, 1808);
    end
    chk("t1_ncpl", cpl_cnt, 1);
    chk("t1_first_lat", first_v - acc_c, 1);

    // zero length
    clr_log();
    do_req(32'h2345, 0);
    wait_idle(50);
    chk("t2_ncmd", log_q.size(), 0);
    chk("t2_ncpl", cpl_cnt, 1);
    chk("t2_cpl_lat", cpl_c - acc_c, 2);

    // outstanding limit with dones withheld
    clr_log();
    hold_done = 1'b1;
    do_req(32'h0, 16384);
    repeat (10) @(negedge aclk);
    chk("t3_held_ncmd", log_q.size(), 2);
    chk("t3_held_valid", cmd_valid, 0);
    give_one = 1'b1;
    repeat (3) @(negedge aclk);
    chk("t3_one_ncmd", log_q.size(), 3);
    chk("t3_one_valid", cmd_valid, 0);
    hold_done = 1'b0;
    wait_idle(200);
    chk("t3_ncmd", log_q.size(), 4);
    chk("t3_ncpl", cpl_cnt, 1);

    // backpressure holds the command stable
    clr_log();
    rdy_low = 1'b1;
    do_req(32'h5000, 9000);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t4_hold_valid", cmd_valid, 1);
      chk("t4_hold_paddr", cmd_paddr, 32'h5000);
      chk("t4_hold_len", cmd_len, 4096);
    end
    rdy_low = 1'b0;
    wait_idle(200);
    chk("t4_ncmd", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t4_a2", log_q[2].a, 32'h7000);
      chk("t4_n2", log_q[2].n, 808);
    end

    // spurious done in idle sets a sticky error
    give_spur = 1'b1;
    repeat (3) @(negedge aclk);
    chk("t5_err", err, 1);
    do_req(32'h9000, 100);
    wait_idle(100);
    chk("t5_err_sticky", err, 1);

    // reset while draining
    clr_log();
    hold_done = 1'b1;
    do_req(32'h8000, 8192);
    k = 0;
    while (log_q.size() < 2 && k < 100) begin
      @(negedge aclk);
      k++;
    end
    chk("t6_issue_wait", k < 100, 1);
    repeat (2) @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    chk("t6_rst_valid", cmd_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cpl", s_cpl, 0);
    chk("t6_rst_ready", s_req_ready, 0);
    chk("t6_rst_paddr", cmd_paddr, 0);
    chk("t6_rst_len", cmd_len, 0);
    chk("t6_rst_err", err, 0);
    repeat (2) @(posedge aclk);
    #1;
    hold_done = 1'b0;
    aresetn = 1'b1;
    repeat (12) @(negedge aclk);
    chk("t6_ncpl", cpl_cnt, 0);
    chk("t6_err", err, 0);

`ifdef CDMA_SPLIT_4K_EN
    clr_log();
    do_req(32'h0F00, 32'h300);
    wait_idle(100);
    chk("t7_ncmd", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t7_a0", log_q[0].a, 32'h0F00);
      chk("t7_n0", log_q[0].n, 32'h100);
      chk("t7_a1", log_q[1].a, 32'h1000);
      chk("t7_n1", log_q[1].n, 32'h200);
    end
`endif

    // randomized traffic
    rdy_pct = 70;
    dly_min = 1;
    dly_max = 6;
    for (int r = 0; r < 40; r++) begin
      logic [LB-1:0] n;
      if ($urandom_range(9) == 0) n = '0;
      else n = LB'($urandom_range(5 * MC + 100, 1));
      do_req(AB'($urandom), n);
      repeat ($urandom_range(3)) @(negedge aclk);
    end
    wait_idle(400);
    chk("rand_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
